serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice iterated LSB-first over WIDTH cycles.
// Operands are captured on start; sum/cout/ovf hold from the done cycle until the next accepted start.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    // state | meaning
    // IDLE  | waiting for start; with loaded=1, operands captured, RUN follows
    // RUN   | one sum bit per cycle, WIDTH cycles
    // DONE  | result valid, done pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             loaded;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cout_q;
    logic             ovf_q;

    logic             accept;
    logic             last_bit;
    logic             sbit;
    logic             cnext;

    assign accept   = (state == IDLE) && !loaded && start;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign sbit     = a_sh[0] ^ b_sh[0] ^ carry;
    assign cnext    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (loaded) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            loaded <= accept;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                res   <= {sbit, res[WIDTH-1:1]};
                carry <= cnext;
                cnt   <= cnt + CW'(1);
                // carry register holds the carry into the MSB on the final bit
                if (last_bit) begin
                    cout_q <= cnext;
                    ovf_q  <= carry ^ cnext;
                end
            end
        end
    end

    assign busy = (state != IDLE) || loaded;
    assign done = (state == DONE);
    assign sum  = res;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
